// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu among REQS valid/ready requesters.
// The result is registered per accept and returned to its owner; an optional lock supports carry chains.

`ifndef ALU_ADD
`define ALU_ADD    6'd0
`define ALU_SUB    6'd1
`define ALU_AND    6'd2
`define ALU_OR     6'd3
`define ALU_XOR    6'd4
`define ALU_LSL    6'd5
`define ALU_LSR    6'd6
`define ALU_MUL    6'd7
`define ALU_SIGNED 6'b100000
`endif

module alu #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [5:0]   op,
  input  logic         cin,
  output logic [n-1:0] out,
  output logic         cout,
  output logic         overflow,
  output logic         sign,
  output logic         zero
);

  logic [5:0]     code;
  logic           is_signed;
  logic [n-1:0]   bx;
  logic [n:0]     sum;
  logic [2*n-1:0] prod;

  // SUB is a + ~b + cin, so a plain subtract is issued with cin=1
  always_comb begin
    code      = op & ~`ALU_SIGNED;
    is_signed = |(op & `ALU_SIGNED);
    bx        = (code == `ALU_SUB) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, bx} + {{n{1'b0}}, cin};
    if (is_signed)
      prod = $signed({{n{a[n-1]}}, a}) * $signed({{n{b[n-1]}}, b});
    else
      prod = {{n{1'b0}}, a} * {{n{1'b0}}, b};
    out      = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (code)
      `ALU_ADD, `ALU_SUB: begin
        out      = sum[n-1:0];
        cout     = sum[n];
        overflow = is_signed ? ((a[n-1] == bx[n-1]) && (sum[n-1] != a[n-1])) : sum[n];
      end
      `ALU_AND: out = a & b;
      `ALU_OR:  out = a | b;
      `ALU_XOR: out = a ^ b;
      `ALU_LSL: out = a << b;
      `ALU_LSR: begin
        if (is_signed) out = $signed(a) >>> b;
        else           out = a >> b;
      end
      // overflow flags a product that does not fit the n-bit result
      `ALU_MUL: begin
        out      = prod[n-1:0];
        overflow = is_signed ? ~((&prod[2*n-1:n-1]) | ~(|prod[2*n-1:n-1]))
                             : |prod[2*n-1:n];
      end
      default: ;
    endcase
    sign = out[n-1];
    zero = ~|out;
  end

endmodule

module alu_arbiter #(
  parameter int n    = 8,
  parameter int REQS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQS-1:0]   req_valid,
  output logic [REQS-1:0]   req_ready,
  input  logic [REQS*n-1:0] req_a,
  input  logic [REQS*n-1:0] req_b,
  input  logic [REQS*6-1:0] req_op,
  input  logic [REQS-1:0]   req_cin,
  input  logic [REQS-1:0]   req_lock,
  output logic [REQS-1:0]   rsp_valid,
  input  logic [REQS-1:0]   rsp_ready,
  output logic [n-1:0]      rsp_out,
  output logic              rsp_cout,
  output logic              rsp_overflow,
  output logic              rsp_sign,
  output logic              rsp_zero,
  output logic              busy
);

  localparam int PW = (REQS > 2) ? 2 : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, owner, lock_owner, grant_idx, next_ptr, cand;
  logic            lock_active, grant_found, handshake, free, accept;
  logic [REQS-1:0] grant_onehot;
  int              scan_idx;
  logic [n-1:0]    alu_out;
  logic            alu_cout, alu_overflow, alu_sign, alu_zero;

  alu #(n) u_alu (
    .a        (req_a[grant_idx*n +: n]),
    .b        (req_b[grant_idx*n +: n]),
    .op       (req_op[grant_idx*6 +: 6]),
    .cin      (req_cin[grant_idx]),
    .out      (alu_out),
    .cout     (alu_cout),
    .overflow (alu_overflow),
    .sign     (alu_sign),
    .zero     (alu_zero)
  );

  // Grant selection: lock owner only while locked, otherwise first valid from ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    cand        = '0;
    if (lock_active) begin
      grant_found = req_valid[lock_owner];
      grant_idx   = lock_owner;
    end else begin
      for (int k = 0; k < REQS; k++) begin
        scan_idx = int'(ptr) + k;
        if (scan_idx >= REQS) scan_idx = scan_idx - REQS;
        cand = scan_idx[PW-1:0];
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    next_ptr     = (int'(grant_idx) == REQS - 1) ? '0 : grant_idx + 1'b1;
    grant_onehot = {{(REQS-1){1'b0}}, 1'b1} << grant_idx;
    handshake    = (state == HOLD) && rsp_valid[owner] && rsp_ready[owner];
    free         = (state == IDLE) || handshake;
    accept       = rst_n && free && grant_found;
    req_ready    = accept ? grant_onehot : '0;
    busy         = (state == HOLD);
  end

  always_comb begin
    state_next = state;
    if (accept)         state_next = HOLD;
    else if (handshake) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Result capture, ownership and lock/pointer bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      owner        <= '0;
      lock_active  <= 1'b0;
      lock_owner   <= '0;
      rsp_valid    <= '0;
      rsp_out      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_sign     <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (accept) begin
      owner        <= grant_idx;
      rsp_valid    <= grant_onehot;
      rsp_out      <= alu_out;
      rsp_cout     <= alu_cout;
      rsp_overflow <= alu_overflow;
      rsp_sign     <= alu_sign;
      rsp_zero     <= alu_zero;
      if (lock_active) begin
        if (!req_lock[grant_idx]) begin
          lock_active <= 1'b0;
          ptr         <= next_ptr;
        end
      end else begin
        ptr <= next_ptr;
        if (req_lock[grant_idx]) begin
          lock_active <= 1'b1;
          lock_owner  <= grant_idx;
        end
      end
    end else if (handshake) begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural arbitration/ALU model.

module tb_alu_arbiter;

  localparam int N = 8;
  localparam int R = 2;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4;
  localparam int OP_LSL = 5, OP_LSR = 6, OP_MUL = 7, OP_SIGNED = 32;

  typedef struct packed {
    logic [N-1:0] out;
    logic         cout;
    logic         ov;
    logic         sign;
    logic         zero;
  } res_t;

  logic           clk, rst_n;
  logic [R-1:0]   req_valid, req_ready, req_cin, req_lock, rsp_valid, rsp_ready;
  logic [R*N-1:0] req_a, req_b;
  logic [R*6-1:0] req_op;
  logic [N-1:0]   rsp_out;
  logic           rsp_cout, rsp_overflow, rsp_sign, rsp_zero, busy;

  int   compared = 0;
  int   mismatched = 0;
  bit   m_hold, m_lock;
  int   m_owner, m_ptr, m_lock_owner;
  res_t m_res;

  alu_arbiter #(.n(N), .REQS(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_cin      (req_cin),
    .req_lock     (req_lock),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow),
    .rsp_sign     (rsp_sign),
    .rsp_zero     (rsp_zero),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // ALU reference computed from the op semantics with integer arithmetic
  function automatic res_t refAlu(input int a, input int b, input int op, input int cin);
    res_t r;
    int code, sa, sb, full, sv, o, prod;
    bit sgn, c, v;
    code = op & 31;
    sgn  = ((op >> 5) & 1) != 0;
    sa   = (sgn && a >= 128) ? a - 256 : a;
    sb   = (sgn && b >= 128) ? b - 256 : b;
    o = 0; c = 0; v = 0;
    case (code)
      OP_ADD: begin
        full = a + b + cin; o = full & 255; c = full > 255;
        sv = sa + sb + cin;
        v = sgn ? (sv > 127 || sv < -128) : c;
      end
      OP_SUB: begin
        full = a + (255 - b) + cin; o = full & 255; c = full > 255;
        sv = sa - sb - 1 + cin;
        v = sgn ? (sv > 127 || sv < -128) : c;
      end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_LSL: o = (b >= 8) ? 0 : ((a << b) & 255);
      OP_LSR: begin
        if (sgn) o = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
        else     o = (b >= 8) ? 0 : (a >> b);
      end
      OP_MUL: begin
        prod = sgn ? sa * sb : a * b;
        o = prod & 255;
        v = sgn ? (prod > 127 || prod < -128) : (prod > 255);
      end
      default: o = 0;
    endcase
    r.out  = o[N-1:0];
    r.cout = c;
    r.ov   = v;
    r.sign = o[7];
    r.zero = (o == 0);
    return r;
  endfunction

  task automatic modelReset();
    m_hold = 0; m_lock = 0; m_owner = 0; m_ptr = 0; m_lock_owner = 0; m_res = '0;
  endtask

  task automatic setReq(input int i, input bit v, input int a, input int b, input int op,
                        input bit cin, input bit lock);
    req_valid[i]      = v;
    req_a[i*N +: N]   = N'(a);
    req_b[i*N +: N]   = N'(b);
    req_op[i*6 +: 6]  = 6'(op);
    req_cin[i]        = cin;
    req_lock[i]       = lock;
  endtask

  // One clock: check all outputs at negedge against the model, then advance the model
  task automatic applyStimulus();
    int win;
    @(negedge clk);
    win = -1;
    if (!m_hold || rsp_ready[m_owner]) begin
      if (m_lock) begin
        if (req_valid[m_lock_owner]) win = m_lock_owner;
      end else begin
        for (int k = 0; k < R; k++) begin
          int c;
          c = (m_ptr + k) % R;
          if (win < 0 && req_valid[c]) win = c;
        end
      end
    end
    checkOutput("req_ready", req_ready, (win >= 0) ? (1 << win) : 0);
    checkOutput("rsp_valid", rsp_valid, m_hold ? (1 << m_owner) : 0);
    checkOutput("busy", busy, m_hold);
    checkOutput("rsp_out", rsp_out, m_res.out);
    checkOutput("rsp_cout", rsp_cout, m_res.cout);
    checkOutput("rsp_overflow", rsp_overflow, m_res.ov);
    checkOutput("rsp_sign", rsp_sign, m_res.sign);
    checkOutput("rsp_zero", rsp_zero, m_res.zero);
    if (win >= 0) begin
      m_hold  = 1;
      m_owner = win;
      m_res   = refAlu(req_a[win*N +: N], req_b[win*N +: N], req_op[win*6 +: 6], req_cin[win]);
      if (m_lock) begin
        if (!req_lock[win]) begin
          m_lock = 0;
          m_ptr  = (win + 1) % R;
        end
      end else begin
        m_ptr = (win + 1) % R;
        if (req_lock[win]) begin
          m_lock = 1;
          m_lock_owner = win;
        end
      end
    end else if (m_hold && rsp_ready[m_owner]) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req_valid = '1; req_lock = '0; req_cin = '0; rsp_ready = '1;
    req_a = '0; req_b = '0; req_op = '0;
    #1;
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_out", rsp_out, 0);
    modelReset();
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    applyReset();

    // Unsigned carry-out and zero result
    setReq(0, 1, 255, 1, OP_ADD, 0, 0);
    applyStimulus();
    checkOutput("t1_valid", rsp_valid, 2'b01);
    checkOutput("t1_out", rsp_out, 0);
    checkOutput("t1_zero", rsp_zero, 1);
    checkOutput("t1_cout", rsp_cout, 1);
    req_valid = '0;
    applyStimulus();

    // Both requesters valid every cycle: grants alternate starting at 0
    applyReset();
    setReq(0, 1, 1, 1, OP_ADD, 0, 0);
    setReq(1, 1, 127, 1, OP_ADD | OP_SIGNED, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("t2_owner", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput("t2_out", rsp_out, (k % 2 == 0) ? 8'd2 : 8'h80);
      checkOutput("t2_ov", rsp_overflow, (k % 2 == 0) ? 0 : 1);
    end

    // Locked two-word add while requester 1 competes
    applyReset();
    setReq(1, 1, 5, 5, OP_ADD, 0, 0);
    setReq(0, 1, 8'hFF, 8'h01, OP_ADD, 0, 1);
    applyStimulus();
    checkOutput("t3_lo_owner", rsp_valid, 2'b01);
    checkOutput("t3_lo_out", rsp_out, 0);
    setReq(0, 1, 8'h01, 8'h00, OP_ADD, rsp_cout, 0);
    applyStimulus();
    checkOutput("t3_hi_owner", rsp_valid, 2'b01);
    checkOutput("t3_hi_out", rsp_out, 8'h02);
    req_valid[0] = 1'b0;
    applyStimulus();
    checkOutput("t3_next_owner", rsp_valid, 2'b10);
    checkOutput("t3_next_out", rsp_out, 8'd10);

    // Backpressure on the owner, then handshake with same-cycle accept
    applyReset();
    rsp_ready = 2'b00;
    setReq(0, 1, 3, 4, OP_ADD, 0, 0);
    setReq(1, 0, 10, 20, OP_ADD, 0, 0);
    applyStimulus();
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("t4_busy", busy, 1);
      checkOutput("t4_ready", req_ready, 0);
      checkOutput("t4_out", rsp_out, 7);
      checkOutput("t4_valid", rsp_valid, 2'b01);
    end
    rsp_ready = 2'b01;
    applyStimulus();
    checkOutput("t4_new_owner", rsp_valid, 2'b10);
    checkOutput("t4_new_out", rsp_out, 30);
    rsp_ready = 2'b11;
    req_valid = '0;
    applyStimulus();

    // Signed multiply and logical shift right for requester 1
    applyReset();
    setReq(1, 1, 8'hFD, 7, OP_MUL | OP_SIGNED, 0, 0);
    applyStimulus();
    checkOutput("t5_mul_out", rsp_out, 8'hEB);
    checkOutput("t5_mul_valid", rsp_valid, 2'b10);
    setReq(1, 1, 8'b00111010, 2, OP_LSR, 0, 0);
    applyStimulus();
    checkOutput("t5_lsr_out", rsp_out, 8'b00001110);
    checkOutput("t5_lsr_valid", rsp_valid, 2'b10);
    req_valid = '0;
    applyStimulus();

    // Asynchronous reset while holding a locked result
    applyReset();
    rsp_ready = 2'b00;
    setReq(0, 1, 1, 1, OP_ADD, 0, 1);
    setReq(1, 1, 2, 2, OP_ADD, 0, 0);
    applyStimulus();
    checkOutput("t6_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", rsp_valid, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_ready", req_ready, 0);
    checkOutput("t6_rst_out", rsp_out, 0);
    modelReset();
    rst_n = 1'b1;
    req_lock = '0;
    rsp_ready = 2'b11;
    applyStimulus();
    checkOutput("t6_first_owner", rsp_valid, 2'b01);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < R; i++) begin
        int op, b;
        op = $urandom_range(0, 7);
        b  = (op == OP_LSL || op == OP_LSR) ? $urandom_range(0, 9) : $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 1) op = op | OP_SIGNED;
        setReq(i, $urandom_range(0, 3) != 0, $urandom_range(0, 255), b, op,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      end
      rsp_ready = R'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one `alu` instance between REQS independent requesters, such as a decode unit and a multi-precision sequencer. Requests use a valid/ready handshake with round-robin arbitration. Each accepted operation's result and flags are registered and returned to the requester that issued it. An optional lock keeps the grant with one requester so it can chain cout into cin for multi-word arithmetic.

Parameters:
n, 8, ALU data width; passed to the internal `alu #(n)`.
REQS, 2, number of requesters; legal range 2..4.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  REQS  per-requester request valid.
req_ready  output  REQS  per-requester accept; at most one bit high per cycle.
req_a  input  REQS*n  operand a; requester i occupies bits [i*n +: n].
req_b  input  REQS*n  operand b; same packing as req_a.
req_op  input  REQS*6  ALU op code, `ALU_*` defines including the `ALU_SIGNED` flag; requester i occupies [i*6 +: 6].
req_cin  input  REQS  carry-in per requester.
req_lock  input  REQS  1 = keep the grant with this requester after this op.
rsp_valid  output  REQS  result valid; only the bit of the op's owner is high.
rsp_ready  input  REQS  per-requester result accept.
rsp_out  output  n  registered ALU result; shared by all requesters.
rsp_cout, rsp_overflow, rsp_sign, rsp_zero  output  1 each  registered ALU flags.
busy  output  1  high while a result is held (state HOLD).

Behaviour:
- Datapath:
  - The winning requester's a, b, op and cin are muxed straight into the internal `alu`.
  - On accept, out, cout, overflow, sign and zero are captured into the rsp_* registers.
  - No other arithmetic is done in this block.
- States: IDLE (no result held) and HOLD (result held, owner recorded).
- Free condition: state==IDLE, or state==HOLD and rsp_valid[owner] & rsp_ready[owner] in this cycle.
  - The free condition therefore has a combinational path from rsp_ready to req_ready, which is intended.
  - This gives back-to-back throughput of one op per cycle.
- Arbitration when free and no lock is active:
  - Scan requesters starting at pointer ptr, wrapping modulo REQS.
  - The first i with req_valid[i] wins, and req_ready[i]=1 in that cycle.
  - On accept, ptr <= (i+1) mod REQS.
- Lock:
  - An accepted request with req_lock=1 sets lock_active and lock_owner=i.
  - While lock_active, only lock_owner can be granted, and ptr does not advance.
  - The first accepted lock_owner request with req_lock=0 clears lock_active, and ptr <= (lock_owner+1) mod REQS.
  - Other requesters wait indefinitely while a lock is active; this is by design.
- Transitions:
  - Accept: state <= HOLD, owner <= i, rsp_valid <= one-hot(i), result registers load.
  - In HOLD, a response handshake with no new accept: state <= IDLE, rsp_valid <= 0, rsp_* keep their last values.
  - Handshake and new accept in the same cycle: stay in HOLD with the new owner and new results.
  - In HOLD with rsp_ready[owner]=0: all rsp_* and owner hold steady and no req_ready is asserted.
  - rsp_ready bits of non-owners are ignored.
- Latency: a request accepted in cycle t has its result on rsp_* from cycle t+1 until its response handshake completes.
- req_* inputs are sampled only in the accept cycle; they may change freely after it.
- Reset (asynchronous, any time including mid-HOLD):
  - state=IDLE, ptr=0, lock_active=0, owner=0.
  - rsp_valid=0, rsp_out=0, all rsp flags=0, busy=0.
  - req_ready is combinational and therefore 0 while rst_n=0.
  - Any held result is discarded.
- busy = (state==HOLD).

Test Plan:
1. Requester 0 issues `ALU_ADD` with a=255, b=1, cin=0 -> req_ready[0] in the same cycle; next cycle rsp_valid=01, rsp_out=0, zero=1, cout=1.
2. Requesters 0 and 1 both valid every cycle with rsp_ready held at 1; 0 sends 1+1, 1 sends 127+1 signed -> grants alternate 0,1,0,1 starting at 0. Results: 2 for requester 0, and -128 with overflow=1, sign=1 for requester 1.
3. Lock chain while requester 1 also requests:
   - Stimulus: requester 0 sends ADD 0xFF+0x01 with lock=1, then ADD 0x01+0x00 with lock=0 and cin taken from the returned cout.
   - Response: both ops of requester 0 are granted before requester 1; the high-byte result is 0x02 and requester 1 is served next.
4. Backpressure: result held with rsp_ready[owner]=0 for 5 cycles -> rsp_* stable, busy=1, no req_ready despite pending valids; raising rsp_ready completes the handshake and allows a same-cycle accept.
5. Ops via arbiter: requester 1 sends `ALU_MUL|ALU_SIGNED` with -3, 7 -> rsp_out=-21. It then sends `ALU_LSR` with 8'b00111010, 2 -> rsp_out=8'b00001110, delivered only to requester 1.
6. Reset: assert rst_n=0 in HOLD with lock active -> rsp_valid=0, busy=0 immediately. After release, with both requesters valid, requester 0 is granted first.
